// File: rtl/pci_rr_arbiter.sv
// PCI bus arbiter: parks the bus on PARK_MASTER and grants requesters in
// round-robin or fixed priority. A grant is withdrawn if FRAME# does not start a transaction in time.
module pci_rr_arbiter #(
  parameter int N_MASTERS   = 3,
  parameter int RR_MODE     = 1,
  parameter int PARK_MASTER = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 FRAME,
  input  logic                 IRDY,
  input  logic [N_MASTERS-1:0] REQ,
  output logic [N_MASTERS-1:0] GNT,
  output logic [N_MASTERS-1:0] mux_control,
  output logic                 timeout_evt
);

  localparam int IW = $clog2(N_MASTERS);
  localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);
  localparam logic [IW-1:0] LAST_RST = IW'(N_MASTERS - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PARK  = 2'd0,
    S_TURN  = 2'd1,
    S_GRANT = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [7:0]             timer_q, timer_d;
  logic [N_MASTERS-1:0]   mux_q, mux_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic                   tevt_q, tevt_d;
  logic [N_MASTERS-1:0]   req_act_s;
  logic                   any_req_s;
  logic                   bus_idle_s;
  logic [IW-1:0]          win_s;

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
    return {{(N_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin searches the N slots after last_served, so last_served itself is tried last.
  function automatic logic [IW-1:0] pick_winner(input logic [N_MASTERS-1:0] act,
                                                input logic [IW-1:0] last);
    logic [IW-1:0] win;
    logic [IW-1:0] ix;
    logic          found;
    logic          take;
    int            pos;
    win   = IW'(0);
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (RR_MODE != 0) begin
        pos = int'(last) + k;
        pos = (pos >= N_MASTERS) ? pos - N_MASTERS : pos;
      end else begin
        pos = k - 1;
      end
      ix    = IW'(pos);
      take  = !found && act[ix];
      win   = take ? ix : win;
      found = found | take;
    end
    return win;
  endfunction

  assign req_act_s  = ~REQ;
  assign any_req_s  = |req_act_s;
  assign bus_idle_s = FRAME & IRDY;
  assign win_s      = pick_winner(req_act_s, last_q);

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_PARK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bookkeeping logic
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    timer_d = timer_q;
    mux_d   = mux_q;
    tevt_d  = 1'b0;
    case (state_q)
      S_PARK: begin
        if (!any_req_s) begin
          state_d = S_PARK;
        end else if (win_s == PARK_IDX) begin
          state_d = S_GRANT;
          gidx_d  = win_s;
          timer_d = 8'd0;
        end else begin
          state_d = S_TURN;
        end
      end
      S_TURN, S_BUSY: begin
        if (state_q == S_BUSY && !bus_idle_s) begin
          state_d = S_BUSY;
        end else if (any_req_s) begin
          state_d = S_GRANT;
          gidx_d  = win_s;
          timer_d = 8'd0;
        end else begin
          state_d = S_PARK;
        end
      end
      S_GRANT: begin
        if (!FRAME) begin
          state_d = S_BUSY;
          mux_d   = onehot(gidx_q);
          last_d  = gidx_q;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_TURN;
          tevt_d  = 1'b1;
          last_d  = gidx_q;
        end else if (REQ[gidx_q]) begin
          state_d = S_TURN;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = S_PARK;
      end
    endcase
  end

  // Grant pattern for the state being entered
  always_comb begin
    gnt_d = {N_MASTERS{1'b1}};
    case (state_d)
      S_PARK:  gnt_d = ~onehot(PARK_IDX);
      S_GRANT: gnt_d = ~onehot(gidx_d);
      default: gnt_d = {N_MASTERS{1'b1}};
    endcase
  end

  // Registered outputs and arbitration history
  always_ff @(posedge clk) begin
    if (RST) begin
      gidx_q  <= PARK_IDX;
      last_q  <= LAST_RST;
      timer_q <= 8'd0;
      mux_q   <= onehot(PARK_IDX);
      gnt_q   <= ~onehot(PARK_IDX);
      tevt_q  <= 1'b0;
    end else begin
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      mux_q   <= mux_d;
      gnt_q   <= gnt_d;
      tevt_q  <= tevt_d;
    end
  end

  assign GNT         = gnt_q;
  assign mux_control = mux_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: a round-robin and a fixed-priority instance, each
// checked every cycle against a transaction-level reference model.
module tb_pci_rr_arbiter;

  localparam int PH_PARK  = 0;
  localparam int PH_TURN  = 1;
  localparam int PH_GRANT = 2;
  localparam int PH_BUSY  = 3;
  localparam int TMO      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_i [2];
  logic       irdy_i  [2];
  logic [2:0] req_i   [2];
  logic [2:0] gnt0, gnt1, mux0, mux1;
  logic       tevt0, tevt1;
  logic [2:0] gnt_o [2];
  logic [2:0] mux_o [2];
  logic       tevt_o[2];

  int checks = 0;
  int errors = 0;

  int   m_phase[2], m_gidx[2], m_last[2], m_held[2], m_mux[2];
  logic m_tevt[2];

  always #5 clk = ~clk;

  pci_rr_arbiter #(.N_MASTERS(3), .RR_MODE(1), .PARK_MASTER(0), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .RST(rst), .FRAME(frame_i[0]), .IRDY(irdy_i[0]), .REQ(req_i[0]),
    .GNT(gnt0), .mux_control(mux0), .timeout_evt(tevt0));

  pci_rr_arbiter #(.N_MASTERS(3), .RR_MODE(0), .PARK_MASTER(0), .TIMEOUT(TMO)) dut_fx (
    .clk(clk), .RST(rst), .FRAME(frame_i[1]), .IRDY(irdy_i[1]), .REQ(req_i[1]),
    .GNT(gnt1), .mux_control(mux1), .timeout_evt(tevt1));

  assign gnt_o[0] = gnt0;  assign gnt_o[1] = gnt1;
  assign mux_o[0] = mux0;  assign mux_o[1] = mux1;
  assign tevt_o[0] = tevt0; assign tevt_o[1] = tevt1;

  // Winner among active-low requests; -1 when nobody asks.
  function automatic int winner(input bit rr, input int last, input logic [2:0] rq);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = rr ? (last + k) % 3 : k - 1;
      if (rq[i[1:0]] == 1'b0) return i;
    end
    return -1;
  endfunction

  task automatic start_grant(input int d, input int w);
    m_phase[d] = PH_GRANT;
    m_gidx[d]  = w;
    m_held[d]  = 0;
  endtask

  task automatic model_edge(input int d, input logic r, input logic fr, input logic ir,
                            input logic [2:0] rq);
    int w;
    w = winner(d == 0, m_last[d], rq);
    m_tevt[d] = 1'b0;
    if (r) begin
      m_phase[d] = PH_PARK; m_mux[d] = 0; m_last[d] = 2; m_gidx[d] = 0; m_held[d] = 0;
    end else begin
      case (m_phase[d])
        PH_PARK:  if (w == 0) start_grant(d, w); else if (w > 0) m_phase[d] = PH_TURN;
        PH_TURN:  if (w >= 0) start_grant(d, w); else m_phase[d] = PH_PARK;
        PH_GRANT: begin
          m_held[d] = m_held[d] + 1;
          if (!fr) begin
            m_phase[d] = PH_BUSY; m_mux[d] = m_gidx[d]; m_last[d] = m_gidx[d];
          end else if (m_held[d] == TMO) begin
            m_phase[d] = PH_TURN; m_tevt[d] = 1'b1; m_last[d] = m_gidx[d];
          end else if (rq[m_gidx[d][1:0]]) begin
            m_phase[d] = PH_TURN;
          end
        end
        PH_BUSY: if (fr && ir) begin
          if (w >= 0) start_grant(d, w); else m_phase[d] = PH_PARK;
        end
        default: m_phase[d] = PH_PARK;
      endcase
    end
  endtask

  function automatic logic [2:0] exp_gnt(input int d);
    if (m_phase[d] == PH_PARK)  return 3'b110;
    if (m_phase[d] == PH_GRANT) return 3'b111 & ~(3'b001 << m_gidx[d]);
    return 3'b111;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic [2:0] eg, em;
    for (int d = 0; d < 2; d++) model_edge(d, rst, frame_i[d], irdy_i[d], req_i[d]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      eg = exp_gnt(d);
      em = 3'b001 << m_mux[d];
      checks = checks + 3;
      if (gnt_o[d] !== eg) begin
        errors++; $display("FAIL model_gnt dut%0d t=%0t: got %b want %b", d, $time, gnt_o[d], eg);
      end
      if (mux_o[d] !== em) begin
        errors++; $display("FAIL model_mux dut%0d t=%0t: got %b want %b", d, $time, mux_o[d], em);
      end
      if (tevt_o[d] !== m_tevt[d]) begin
        errors++; $display("FAIL model_tevt dut%0d t=%0t: got %b want %b", d, $time, tevt_o[d], m_tevt[d]);
      end
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      frame_i[d] = 1'b1; irdy_i[d] = 1'b1; req_i[d] = 3'b111;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic expect3(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s t=%0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      expect3("reset_gnt", gnt0, 3'b110);
      expect3("reset_mux", mux0, 3'b001);
      expect3("reset_tevt", {2'b00, tevt0}, 3'b000);
      expect3("reset_gnt_fx", gnt1, 3'b110);
    end
  endtask

  task automatic test_park_turn();
    apply_reset();
    req_i[0] = 3'b101;
    tick(); expect3("turn_gnt", gnt0, 3'b111);
    tick(); expect3("grant1_gnt", gnt0, 3'b101);
    frame_i[0] = 1'b0;
    tick(); expect3("busy_gnt", gnt0, 3'b111); expect3("busy_mux", mux0, 3'b010);
    frame_i[0] = 1'b1; req_i[0] = 3'b111;
    tick(); expect3("back_to_park", gnt0, 3'b110); expect3("park_mux_hold", mux0, 3'b010);
  endtask

  // Each granted master runs one address + one data phase; owners must rotate (RR) or stay 0 (fixed).
  task automatic test_owner_order(input int d);
    int waited;
    logic [2:0] want;
    apply_reset();
    req_i[d] = 3'b000;
    for (int k = 0; k < 5; k++) begin
      want = (d == 0) ? (3'b001 << (k % 3)) : 3'b001;
      waited = 0;
      while (m_phase[d] != PH_GRANT && waited < 20) begin tick(); waited++; end
      checks++;
      if (waited >= 20) begin errors++; $display("FAIL owner_wait dut%0d: no grant within %0d cycles", d, waited); end
      expect3("owner_gnt", gnt_o[d], ~want);
      frame_i[d] = 1'b0;
      tick(); expect3("owner_mux", mux_o[d], want);
      frame_i[d] = 1'b1; irdy_i[d] = 1'b0;
      tick();
      irdy_i[d] = 1'b1;
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    req_i[0] = 3'b011;
    tick(); tick(); expect3("tmo_grant2", gnt0, 3'b011);
    for (int i = 1; i < TMO; i++) begin
      tick();
      expect3("tmo_hold_gnt", gnt0, 3'b011);
      expect3("tmo_no_evt", {2'b00, tevt0}, 3'b000);
    end
    tick(); expect3("tmo_evt", {2'b00, tevt0}, 3'b001); expect3("tmo_turn_gnt", gnt0, 3'b111);
    req_i[0] = 3'b010;
    tick(); expect3("tmo_next_gnt", gnt0, 3'b110); expect3("tmo_evt_off", {2'b00, tevt0}, 3'b000);
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_busy();
    apply_reset();
    req_i[0] = 3'b101;
    tick(); tick();
    frame_i[0] = 1'b0;
    tick(); expect3("rb_busy_mux", mux0, 3'b010);
    rst = 1'b1;
    tick(); expect3("rb_gnt", gnt0, 3'b110); expect3("rb_mux", mux0, 3'b001);
    rst = 1'b0; idle_inputs();
    tick(); expect3("rb_park", gnt0, 3'b110);
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(7) == 0) req_i[d] = 3'($urandom);
        frame_i[d] = ($urandom_range(9) != 0);
        irdy_i[d]  = ($urandom_range(3) != 0);
      end
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = PH_PARK; m_gidx[d] = 0; m_last[d] = 2; m_held[d] = 0; m_mux[d] = 0; m_tevt[d] = 1'b0;
    end
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_park_turn();
    test_owner_order(0);
    test_owner_order(1);
    test_timeout();
    test_reset_in_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_rr_arbiter.md
PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 3: number of bus masters; legal range 2..8.
REQ-002 Parameter RR_MODE, default 1: 1 = round-robin priority; 0 = fixed priority, lowest index highest.
REQ-003 Parameter PARK_MASTER, default 0: index granted when no master requests; must be < N_MASTERS.
REQ-004 Parameter TIMEOUT, default 16: cycles a granted master has to assert FRAME before the grant is withdrawn; legal range 2..255.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 FRAME  input  1  PCI FRAME#, active low.
REQ-008 IRDY  input  1  PCI IRDY#, active low.
REQ-009 REQ  input  N_MASTERS  per-master request, active low; bit i = master i.
REQ-010 GNT  output  N_MASTERS  per-master grant, active low; registered.
REQ-011 mux_control  output  N_MASTERS  one-hot, active high: current bus owner select; registered.
REQ-012 timeout_evt  output  1  one-cycle active-high pulse when a grant times out.

Function
REQ-013 Bus idle SHALL be defined as FRAME=1 and IRDY=1 sampled on the same edge.
REQ-014 The block SHALL implement states PARK, TURN, GRANT and BUSY.
REQ-015 At most one GNT bit SHALL be low in any cycle.
REQ-016 Winner, RR_MODE=1: first requesting index strictly after last_served, searching cyclically and wrapping from N_MASTERS-1 to 0.
REQ-017 Winner, RR_MODE=0: lowest requesting index; last_served is ignored.
REQ-018 PARK: GNT[PARK_MASTER]=0, all other GNT bits 1.
REQ-019 PARK, no REQ low: stay in PARK.
REQ-020 PARK, winner == PARK_MASTER: go to GRANT on the next edge, GNT unchanged (grant latency 1 cycle).
REQ-021 PARK, winner != PARK_MASTER: go to TURN (latency 2 cycles).
REQ-022 TURN: all GNT bits 1 for exactly one cycle; then go to GRANT with the recomputed winner if any REQ is low, else to PARK.
REQ-023 GRANT: the winner's GNT bit SHALL be 0; the timer SHALL clear on entry and increment each cycle in GRANT.
REQ-024 GRANT, FRAME sampled 0: go to BUSY; mux_control and last_served take the granted index; all GNT bits go to 1.
REQ-025 GRANT, granted master's REQ sampled 1 with FRAME=1: go to TURN; last_served unchanged.
REQ-026 GRANT, timer reaches TIMEOUT-1 with FRAME=1: pulse timeout_evt, set last_served to the granted index, go to TURN.
REQ-027 FRAME=0 takes precedence over REQ withdrawal and timeout on the same edge.
REQ-028 BUSY: all GNT bits 1; mux_control holds the owner until the next BUSY entry.
REQ-029 BUSY with bus idle: go to GRANT with the winner if any REQ is low, else to PARK (no TURN cycle needed).
REQ-030 mux_control SHALL change only on GRANT->BUSY and on reset; it holds through PARK, TURN and GRANT.
REQ-031 REQ of masters other than the granted one SHALL NOT affect GNT while in GRANT.
REQ-032 The winner computed in PARK or TURN SHALL be the one latched into GRANT; no re-arbitration occurs inside GRANT.

Reset
REQ-033 With RST=1 at an edge, the next state SHALL be:
- state PARK; GNT = all 1 except bit PARK_MASTER = 0
- mux_control = one-hot PARK_MASTER
- last_served = N_MASTERS-1; timer = 0; timeout_evt = 0
REQ-034 Reset SHALL override every state, including BUSY mid-transaction; FRAME, IRDY and REQ are ignored while RST=1.

Verification
(N_MASTERS=3, PARK_MASTER=0, TIMEOUT=16 unless stated.)
REQ-035 Reset, REQ=111 -> GNT=110, mux_control=001, timeout_evt=0; held indefinitely.
REQ-036 PARK, REQ=101 -> next cycle GNT=111, following cycle GNT=101; FRAME=0 -> GNT=111, mux_control=010.
REQ-037 RR_MODE=1, REQ=000 held, each master runs one FRAME transaction then idles -> BUSY owners in order 0,1,2,0,1.
REQ-038 RR_MODE=0, same stimulus -> every BUSY owner is master 0, mux_control=001.
REQ-039 Grant master 2 (REQ=011), FRAME held 1 for 16 cycles -> timeout_evt=1 for one cycle, GNT=111 one cycle, then GNT=110 (master 0) if REQ=010.
REQ-040 RST=1 during BUSY with owner 1 -> next edge GNT=110, mux_control=001, timer 0, state PARK.
